// File: rtl/hack_pkg.sv
// Shared definitions for the Hack data memory block.
//   HACK_WORD_W / HACK_ADDR_W : native Hack word and address-bus widths.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : read-during-write result selectors.
//   ram_state_t : clear-sequencer state encoding.
package hack_pkg;

  localparam int unsigned HACK_WORD_W = 16;
  localparam int unsigned HACK_ADDR_W = 16;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  typedef enum logic {
    RAM_CLEAR,
    RAM_READY
  } ram_state_t;

endpackage

// File: rtl/hack_ram_clear_seq.sv
// Clear sequencer for hack_data_ram. It owns the CLEAR/READY state and the clear pointer, and
// walks the pointer over every word once after reset.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset, restarts the sequence at word 0
//   busy_o     : clear in progress (decoded from the state register)
//   clr_we_o   : clear write strobe for the shared write port
//   clr_addr_o : word currently being cleared
module hack_ram_clear_seq
  import hack_pkg::*;
#(
  parameter int unsigned Depth        = 256,
  parameter int unsigned ClearOnReset = 1,
  localparam int unsigned IdxW        = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            busy_o,
  output logic            clr_we_o,
  output logic [IdxW-1:0] clr_addr_o
);

  ram_state_t      state_q, state_d;
  logic [IdxW-1:0] clr_ptr_q, clr_ptr_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (reset_i) begin
      state_d   = (ClearOnReset != 0) ? RAM_CLEAR : RAM_READY;
      clr_ptr_d = '0;
    end else begin
      unique case (state_q)
        RAM_CLEAR: begin
          // Last word is written on this edge; the pointer parks instead of wrapping.
          if (clr_ptr_q == IdxW'(Depth - 1)) begin
            state_d = RAM_READY;
          end else begin
            clr_ptr_d = clr_ptr_q + IdxW'(1);
          end
        end
        RAM_READY: ;
        default:   state_d = RAM_READY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
  end

  assign busy_o     = (state_q == RAM_CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = clr_ptr_q;

endmodule

// File: rtl/hack_data_ram.sv
// Hack CPU data memory: single-port word RAM with a registered read port, a hardware clear
// sequence after reset, out-of-range detection and selectable read-during-write behaviour.
//   clk      : clock, all logic on the rising edge
//   reset    : synchronous active-high reset
//   data_in  : write data
//   addr     : word address (full Hack bus width)
//   we_M     : write enable
//   data_out : read data for the access issued the previous cycle
//   rd_valid : data_out holds a completed access
//   addr_err : previous-cycle access was out of range
//   busy     : clear in progress, accesses ignored
module hack_data_ram
  import hack_pkg::*;
#(
  parameter int unsigned DATA_W         = HACK_WORD_W,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = HACK_ADDR_W,
  parameter int unsigned RDW_MODE       = RDW_READ_FIRST,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we_M,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || ((64'(DEPTH) - 64'd1) >> ADDR_W) != 64'd0) begin : g_bad_depth
    $fatal(1, "hack_data_ram: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
  end

  logic            clr_we;
  logic [IdxW-1:0] clr_addr;

  hack_ram_clear_seq #(
    .Depth        (DEPTH),
    .ClearOnReset (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (clk),
    .reset_i    (reset),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IdxW-1:0]   acc_idx;
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  // Range check on the full address so high addresses never alias into the array.
  assign in_range = ({1'b0, addr} < DepthExt);
  assign acc_idx  = addr[IdxW-1:0];

  // Single write port shared by the clear sequence and user writes; reset blocks both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = acc_idx;
    mem_wdata = data_in;
    if (!reset) begin
      if (busy) begin
        mem_we    = clr_we;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else begin
        mem_we = we_M && in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    data_out_d = '0;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (!reset && !busy) begin
      rd_valid_d = 1'b1;
      if (in_range) begin
        if (RDW_MODE == RDW_WRITE_FIRST && we_M) begin
          data_out_d = data_in;
        end else begin
          data_out_d = mem[acc_idx];
        end
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
    rd_valid_q <= rd_valid_d;
    addr_err_q <= addr_err_d;
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_hack_data_ram.sv
// Directed bench for hack_data_ram. Three instances share the input bus:
//   u_rf : read-first, clear on reset
//   u_wf : write-first, clear on reset
//   u_nc : read-first, no clear (only written words are read back)
module tb_hack_data_ram;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [15:0] addr;
  logic        we_m;

  logic [15:0] d_rf, d_wf, d_nc;
  logic        v_rf, v_wf, v_nc;
  logic        e_rf, e_wf, e_nc;
  logic        b_rf, b_wf, b_nc;

  int n_checks;
  int n_fail;

  hack_data_ram #(
    .DATA_W (16), .DEPTH (256), .ADDR_W (16), .RDW_MODE (0), .CLEAR_ON_RESET (1)
  ) u_rf (
    .clk (clk), .reset (reset), .data_in (data_in), .addr (addr), .we_M (we_m),
    .data_out (d_rf), .rd_valid (v_rf), .addr_err (e_rf), .busy (b_rf)
  );

  hack_data_ram #(
    .DATA_W (16), .DEPTH (256), .ADDR_W (16), .RDW_MODE (1), .CLEAR_ON_RESET (1)
  ) u_wf (
    .clk (clk), .reset (reset), .data_in (data_in), .addr (addr), .we_M (we_m),
    .data_out (d_wf), .rd_valid (v_wf), .addr_err (e_wf), .busy (b_wf)
  );

  hack_data_ram #(
    .DATA_W (16), .DEPTH (256), .ADDR_W (16), .RDW_MODE (0), .CLEAR_ON_RESET (0)
  ) u_nc (
    .clk (clk), .reset (reset), .data_in (data_in), .addr (addr), .we_M (we_m),
    .data_out (d_nc), .rd_valid (v_nc), .addr_err (e_nc), .busy (b_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that completes an access.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d);
    we_m    = we;
    addr    = a;
    data_in = d;
    step();
    we_m    = 1'b0;
  endtask

  // Counts samples with busy high (starting with the current one); also notes any rd_valid.
  task automatic count_busy(output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (b_rf && n < 1000) begin
      if (v_rf || v_wf) saw_valid = 1'b1;
      n++;
      step();
    end
  endtask

  int   n_busy;
  logic saw_valid;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    we_m     = 1'b0;
    addr     = '0;
    data_in  = '0;

    // Reset, with a write attempted throughout the clear that must be ignored.
    reset = 1'b1;
    step();
    reset   = 1'b0;
    we_m    = 1'b1;
    addr    = 16'd3;
    data_in = 16'h5555;
    check("rst_busy", 32'(b_rf), 1);
    check("rst_data_out", 32'(d_rf), 0);
    check("rst_rd_valid", 32'(v_rf), 0);
    check("rst_addr_err", 32'(e_rf), 0);
    check("nc_rst_busy", 32'(b_nc), 0);
    count_busy(n_busy, saw_valid);
    we_m = 1'b0;
    check("clear_len", 32'(n_busy), 256);
    check("busy_no_valid", 32'(saw_valid), 0);
    check("wf_busy_done", 32'(b_wf), 0);

    access(1'b0, 16'd3, 16'h0);
    check("busy_wr_ignored", 32'(d_rf), 0);
    access(1'b0, 16'd0, 16'h0);
    check("clr_0", 32'(d_rf), 0);
    check("clr_0_valid", 32'(v_rf), 1);
    access(1'b0, 16'd128, 16'h0);
    check("clr_128", 32'(d_rf), 0);
    access(1'b0, 16'd255, 16'h0);
    check("clr_255", 32'(d_rf), 0);
    check("clr_255_valid", 32'(v_rf), 1);

    // Basic write then read.
    access(1'b1, 16'd5, 16'hBEEF);
    check("wr5_rf_old", 32'(d_rf), 0);
    check("wr5_wf_new", 32'(d_wf), 'hBEEF);
    check("wr5_err", 32'(e_rf), 0);
    access(1'b0, 16'd5, 16'h0);
    check("rd5", 32'(d_rf), 'hBEEF);
    check("rd5_valid", 32'(v_rf), 1);
    check("rd5_err", 32'(e_rf), 0);

    // Read-during-write.
    access(1'b1, 16'd7, 16'h1111);
    access(1'b1, 16'd7, 16'h2222);
    check("rdw_rf", 32'(d_rf), 'h1111);
    check("rdw_wf", 32'(d_wf), 'h2222);
    access(1'b0, 16'd7, 16'h0);
    check("rdw_rf_after", 32'(d_rf), 'h2222);
    check("rdw_wf_after", 32'(d_wf), 'h2222);

    // Out of range: no write, no aliasing onto word 0.
    access(1'b1, 16'd256, 16'hDEAD);
    check("oor_err", 32'(e_rf), 1);
    check("oor_data", 32'(d_rf), 0);
    check("oor_valid", 32'(v_rf), 1);
    check("oor_wf_data", 32'(d_wf), 0);
    access(1'b0, 16'hFFFF, 16'h0);
    check("oor_top_err", 32'(e_rf), 1);
    access(1'b0, 16'd0, 16'h0);
    check("oor_no_alias", 32'(d_rf), 0);
    check("oor_err_clears", 32'(e_rf), 0);

    // Preload for the reset tests.
    access(1'b1, 16'd200, 16'hAAAA);
    access(1'b1, 16'd9, 16'h1234);

    // Reset with a write on the bus: discarded in the no-clear instance too.
    we_m    = 1'b1;
    addr    = 16'd9;
    data_in = 16'h9999;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    we_m  = 1'b0;
    check("rst2_busy", 32'(b_rf), 1);
    check("rst2_nc_valid", 32'(v_nc), 0);
    for (int i = 0; i < 100; i++) step();
    check("midclr_busy", 32'(b_rf), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(n_busy, saw_valid);
    check("restart_len", 32'(n_busy), 256);
    check("restart_no_valid", 32'(saw_valid), 0);

    access(1'b0, 16'd200, 16'h0);
    check("rd200_cleared", 32'(d_rf), 0);
    check("rd200_nc_kept", 32'(d_nc), 'hAAAA);
    access(1'b0, 16'd9, 16'h0);
    check("rd9_nc_rst_wr_dropped", 32'(d_nc), 'h1234);
    check("rd9_cleared", 32'(d_wf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
